// File: rtl/eth_frame_rx_param.sv
// Serial Ethernet frame receiver: hunts preamble/SFD, captures header fields,
// streams payload bytes and reports CRC-32 / length / address status per frame.
module eth_frame_rx_param #(
    parameter int          PRE_MIN     = 8,
    parameter int          MAX_PAYLOAD = 1500,
    parameter logic [47:0] MY_MAC      = 48'h0000_0000_0000,
    parameter logic [31:0] CRC_INIT    = 32'hFFFF_FFFF,
    parameter logic [31:0] CRC_XOROUT  = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in,
    input  logic        promisc,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic        pl_last,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] size,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        fcs_err,
    output logic        len_err,
    output logic        addr_miss,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {HUNT, DMAC, SMAC, LEN, PAYLOAD, FCS} state_t;

    localparam int                AW      = $clog2(PRE_MIN + 2);
    localparam logic [AW-1:0]     PRE_SAT = AW'(PRE_MIN);
    localparam logic [16:0]       MAX_LEN = 17'(MAX_PAYLOAD);
    localparam logic [31:0]       POLY    = 32'h04C1_1DB7;

    state_t        state;
    logic [AW-1:0] alt_cnt;
    logic          prev_bit;
    logic [10:0]   bit_cnt;
    logic [15:0]   byte_cnt;
    logic [31:0]   crc;
    logic [30:0]   fcs_sr;
    logic [6:0]    byte_sr;

    logic [31:0]   crc_next;
    logic [31:0]   fcs_next;
    logic [15:0]   len_next;
    logic          fcs_bad;
    logic          miss;

    always_comb begin
        crc_next = {crc[30:0], 1'b0} ^ ((crc[31] ^ in) ? POLY : 32'h0);
        fcs_next = {fcs_sr, in};
        len_next = {size[14:0], in};
        fcs_bad  = (fcs_next != (crc ^ CRC_XOROUT));
        miss     = (dst_mac != MY_MAC) && (dst_mac != 48'hFFFF_FFFF_FFFF) && !promisc;
    end

    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= HUNT;
            alt_cnt    <= '0;
            prev_bit   <= 1'b0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            crc        <= CRC_INIT;
            fcs_sr     <= '0;
            byte_sr    <= '0;
            pl_data    <= '0;
            pl_valid   <= 1'b0;
            pl_last    <= 1'b0;
            dst_mac    <= '0;
            src_mac    <= '0;
            size       <= '0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            fcs_err    <= 1'b0;
            len_err    <= 1'b0;
            addr_miss  <= 1'b0;
        end else begin
            pl_valid   <= 1'b0;
            pl_last    <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            fcs_err    <= 1'b0;
            len_err    <= 1'b0;
            addr_miss  <= 1'b0;
            case (state)
                HUNT: begin
                    prev_bit <= in;
                    if (in != prev_bit) begin
                        if (alt_cnt < PRE_SAT) alt_cnt <= alt_cnt + AW'(1);
                    end else if (in && (alt_cnt >= PRE_SAT)) begin
                        state    <= DMAC;
                        crc      <= CRC_INIT;
                        bit_cnt  <= 11'd47;
                        alt_cnt  <= '0;
                        prev_bit <= 1'b0;
                    end else begin
                        alt_cnt <= '0;
                    end
                end
                DMAC: begin
                    dst_mac <= {dst_mac[46:0], in};
                    crc     <= crc_next;
                    if (bit_cnt == 11'd0) begin
                        state   <= SMAC;
                        bit_cnt <= 11'd47;
                    end else begin
                        bit_cnt <= bit_cnt - 11'd1;
                    end
                end
                SMAC: begin
                    src_mac <= {src_mac[46:0], in};
                    crc     <= crc_next;
                    if (bit_cnt == 11'd0) begin
                        state   <= LEN;
                        bit_cnt <= 11'd15;
                    end else begin
                        bit_cnt <= bit_cnt - 11'd1;
                    end
                end
                LEN: begin
                    size <= len_next;
                    crc  <= crc_next;
                    if (bit_cnt == 11'd0) begin
                        // Oversized frames are dropped right here; nothing further is consumed.
                        if ({1'b0, len_next} > MAX_LEN) begin
                            frame_done <= 1'b1;
                            len_err    <= 1'b1;
                            state      <= HUNT;
                        end else if (len_next == 16'd0) begin
                            state   <= FCS;
                            bit_cnt <= 11'd31;
                        end else begin
                            state    <= PAYLOAD;
                            bit_cnt  <= 11'd7;
                            byte_cnt <= 16'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 11'd1;
                    end
                end
                PAYLOAD: begin
                    byte_sr <= {byte_sr[5:0], in};
                    crc     <= crc_next;
                    if (bit_cnt == 11'd0) begin
                        pl_valid <= 1'b1;
                        pl_data  <= {byte_sr, in};
                        if (byte_cnt == size) begin
                            pl_last <= 1'b1;
                            state   <= FCS;
                            bit_cnt <= 11'd31;
                        end else begin
                            byte_cnt <= byte_cnt + 16'd1;
                            bit_cnt  <= 11'd7;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 11'd1;
                    end
                end
                FCS: begin
                    fcs_sr <= fcs_next[30:0];
                    if (bit_cnt == 11'd0) begin
                        frame_done <= 1'b1;
                        fcs_err    <= fcs_bad;
                        addr_miss  <= miss;
                        frame_ok   <= !fcs_bad && !miss;
                        state      <= HUNT;
                    end else begin
                        bit_cnt <= bit_cnt - 11'd1;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_frame_rx_param.sv
// Directed bench for eth_frame_rx_param: builds serial frames with a bit-serial
// CRC-32 model and checks payload stream and frame status against expectations.
module tb_eth_frame_rx_param;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in = 1'b0;
    logic        promisc = 1'b1;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_last;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] size;
    logic        frame_done;
    logic        frame_ok;
    logic        fcs_err;
    logic        len_err;
    logic        addr_miss;
    logic [2:0]  dbg_state;

    int          checks = 0;
    int          failures = 0;
    int          done_cnt = 0;
    int          ok_cnt = 0;
    int          base_done;
    int          base_ok;
    logic [31:0] crc_m;
    logic [7:0]  pl_buf [16];
    logic [8:0]  exp_q[$];
    logic [8:0]  got_q[$];

    eth_frame_rx_param dut (
        .clock(clock), .reset(reset), .in(in), .promisc(promisc),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
        .dst_mac(dst_mac), .src_mac(src_mac), .size(size),
        .frame_done(frame_done), .frame_ok(frame_ok), .fcs_err(fcs_err),
        .len_err(len_err), .addr_miss(addr_miss), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    // Observed payload bytes and frame-end strobes, sampled mid-cycle.
    always @(negedge clock) begin
        if (pl_valid) got_q.push_back({pl_last, pl_data});
        if (frame_done) begin
            done_cnt++;
            if (frame_ok) ok_cnt++;
        end
    end

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C1_1DB7 : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clock);
        in = b;
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b0);
    endtask

    task automatic send_field(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(v[i]);
            crc_m = crc_step(crc_m, v[i]);
        end
    endtask

    task automatic send_pre(input int pairs);
        repeat (pairs) begin
            send_bit(1'b1);
            send_bit(1'b0);
        end
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] sz, input int npl, input bit flip);
        logic [31:0] fcs;
        send_pre(31);
        crc_m = 32'hFFFF_FFFF;
        send_field(dst, 48);
        send_field(src, 48);
        send_field({32'h0, sz}, 16);
        for (int b = 0; b < npl; b++) begin
            send_field({40'h0, pl_buf[b]}, 8);
            exp_q.push_back({1'(b == npl - 1), pl_buf[b]});
        end
        fcs = crc_m ^ 32'hFFFF_FFFF;
        if (flip) fcs[0] = ~fcs[0];
        for (int i = 31; i >= 0; i--) send_bit(fcs[i]);
    endtask

    // Status must appear exactly one cycle after the last consumed bit.
    task automatic chk_done(input string tag, input logic ok, input logic fe,
                            input logic le, input logic am);
        @(negedge clock);
        #1;
        chk({tag, "_done"}, frame_done, 1'b1);
        chk({tag, "_ok"}, frame_ok, ok);
        chk({tag, "_fcs_err"}, fcs_err, fe);
        chk({tag, "_len_err"}, len_err, le);
        chk({tag, "_addr_miss"}, addr_miss, am);
    endtask

    task automatic chk_payload(input string tag);
        logic [8:0] g;
        logic [8:0] e;
        #1;
        chk({tag, "_pl_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_pl_byte"}, g, e);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        pl_buf[0] = 8'h82;
        pl_buf[1] = 8'h42;
        pl_buf[2] = 8'hC2;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        chk("rst_pl_valid", pl_valid, 1'b0);
        chk("rst_pl_data", pl_data, 8'h00);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_dst_mac", dst_mac, 48'h0);
        chk("rst_src_mac", src_mac, 48'h0);
        chk("rst_size", size, 16'h0);
        chk("rst_state", dbg_state, 3'd0);
        reset = 1'b0;
        idle(2);

        // 1: good frame, promiscuous
        promisc = 1'b1;
        send_frame(48'h0, 48'hFFFF_FFFF_FFFF, 16'h0003, 3, 1'b0);
        chk_done("f1", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("f1_size", size, 16'h0003);
        chk("f1_dst", dst_mac, 48'h0);
        chk("f1_src", src_mac, 48'hFFFF_FFFF_FFFF);
        chk("f1_state", dbg_state, 3'd0);
        chk_payload("f1");
        idle(3);

        // 2: corrupted FCS still streams payload
        send_frame(48'h0, 48'hFFFF_FFFF_FFFF, 16'h0003, 3, 1'b1);
        chk_done("f2", 1'b0, 1'b1, 1'b0, 1'b0);
        chk_payload("f2");
        idle(3);

        // 3: unicast filter
        promisc = 1'b0;
        send_frame(48'h0000_0000_0001, 48'h1234_5678_9ABC, 16'h0003, 3, 1'b0);
        chk_done("f3a", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("f3a_dst", dst_mac, 48'h0000_0000_0001);
        chk("f3a_src", src_mac, 48'h1234_5678_9ABC);
        chk_payload("f3a");
        idle(2);
        send_frame(48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 16'h0003, 3, 1'b0);
        chk_done("f3b", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_payload("f3b");
        idle(2);
        send_frame(48'h0, 48'h1234_5678_9ABC, 16'h0001, 1, 1'b0);
        chk_done("f3c", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_payload("f3c");
        idle(2);
        promisc = 1'b1;

        // 4: oversized length aborts right after the length field
        send_pre(31);
        crc_m = 32'hFFFF_FFFF;
        send_field(48'h0, 48);
        send_field(48'hFFFF_FFFF_FFFF, 48);
        send_field({32'h0, 16'h05DD}, 16);
        chk_done("f4", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("f4_size", size, 16'h05DD);
        chk("f4_state", dbg_state, 3'd0);
        idle(60);
        chk_payload("f4");
        send_frame(48'h0, 48'hFFFF_FFFF_FFFF, 16'h0003, 3, 1'b0);
        chk_done("f4n", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_payload("f4n");
        idle(2);

        // 4b: zero-length frame goes straight to FCS
        send_frame(48'h0, 48'hFFFF_FFFF_FFFF, 16'h0000, 0, 1'b0);
        chk_done("f0", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_payload("f0");
        idle(2);

        // 5: short preamble is ignored; then two zero-gap frames
        base_done = done_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1);
        idle(200);
        #1;
        chk("f5_no_done", done_cnt, base_done);
        chk("f5_state", dbg_state, 3'd0);
        chk_payload("f5");
        base_done = done_cnt;
        base_ok = ok_cnt;
        send_frame(48'h0, 48'hFFFF_FFFF_FFFF, 16'h0003, 3, 1'b0);
        send_frame(48'hFFFF_FFFF_FFFF, 48'h0, 16'h0002, 2, 1'b0);
        idle(3);
        #1;
        chk("f5_b2b_done", done_cnt - base_done, 2);
        chk("f5_b2b_ok", ok_cnt - base_ok, 2);
        chk_payload("f5b");

        // 6: reset during payload
        base_done = done_cnt;
        send_pre(31);
        crc_m = 32'hFFFF_FFFF;
        send_field(48'h0, 48);
        send_field(48'hFFFF_FFFF_FFFF, 48);
        send_field({32'h0, 16'h0003}, 16);
        send_field({40'h0, 8'h82}, 8);
        exp_q.push_back({1'b0, 8'h82});
        send_field({45'h0, 3'b010}, 3);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("f6_rst_state", dbg_state, 3'd0);
        chk("f6_rst_dst", dst_mac, 48'h0);
        chk("f6_rst_src", src_mac, 48'h0);
        chk("f6_rst_size", size, 16'h0);
        chk("f6_rst_pl_data", pl_data, 8'h00);
        reset = 1'b0;
        idle(60);
        #1;
        chk("f6_no_done", done_cnt, base_done);
        chk_payload("f6");
        send_frame(48'h0, 48'hFFFF_FFFF_FFFF, 16'h0003, 3, 1'b0);
        chk_done("f6n", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_payload("f6n");
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
